// File: rtl/calc_pkg.sv
// Shared display constants, payload type, scan FSM encodings and hex to
// seven-segment table.
//   NUM_DIG     digits on the display
//   SEG_BLANK   active-low segment word with every segment off
//   DIG_OFF     active-low digit select with every digit off
//   disp_word_t display payload: four hex nibbles plus four decimal points
//   hex_to_seg  nibble -> active-low segments {a,b,c,d,e,f,g}
package calc_pkg;

    localparam int unsigned NUM_DIG = 4;
    localparam int unsigned SEG_W   = 7;
    localparam int unsigned WORD_W  = 16;

    localparam logic [SEG_W-1:0]   SEG_BLANK = 7'h7F;
    localparam logic [NUM_DIG-1:0] DIG_OFF   = 4'hF;

    // Scan slot phases
    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_SHOW  = 1'b1;

    typedef struct packed {
        logic [WORD_W-1:0]  word;
        logic [NUM_DIG-1:0] dots;
    } disp_word_t;

    function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] nib);
        logic [SEG_W-1:0] seg;
        case (nib)
            4'h0:    seg = 7'h01;
            4'h1:    seg = 7'h4F;
            4'h2:    seg = 7'h12;
            4'h3:    seg = 7'h06;
            4'h4:    seg = 7'h4C;
            4'h5:    seg = 7'h24;
            4'h6:    seg = 7'h20;
            4'h7:    seg = 7'h0F;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h04;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h60;
            4'hC:    seg = 7'h31;
            4'hD:    seg = 7'h42;
            4'hE:    seg = 7'h30;
            default: seg = 7'h38;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment decoder.
//   i_nib     in  4  hex digit
//   o_seg_n_c out 7  segments a..g active-low, [6]=a .. [0]=g
module seg_hex_decode
    import calc_pkg::*;
(
    input  logic [3:0]       i_nib,
    output logic [SEG_W-1:0] o_seg_n_c
);

    assign o_seg_n_c = hex_to_seg(i_nib);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit seven-segment display.
// Each digit owns one slot: a blank phase against ghosting, then a show phase.
// New display words are taken through valid/ready into a pending register and
// only become active at a frame boundary, so a frame is never torn.
//   FPGA_CLK   in   1  clock
//   RESET_BUT  in   1  synchronous reset, active-low
//   upd_valid  in   1  new display word offered
//   upd_data   in  16  nibble i -> digit i ([3:0] rightmost)
//   upd_dots   in   4  decimal points, bit i -> digit i, 1 = lit
//   upd_ready  out  1  word can be accepted
//   dig_en     in   4  per-digit enable (live)
//   lz_blank   in   1  leading-zero blanking (live)
//   dig_n      out  4  digit selects, active-low
//   seg_n      out  7  segments a..g, active-low
//   dp_n       out  1  decimal point, active-low
//   frame_tick out  1  pulse on the last cycle of the digit-3 slot
module seg_scan_ctrl
    import calc_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned SCAN_HZ   = 1000,
    parameter int unsigned BLANK_CYC = 500
) (
    input  logic               FPGA_CLK,
    input  logic               RESET_BUT,
    input  logic               upd_valid,
    input  logic [WORD_W-1:0]  upd_data,
    input  logic [NUM_DIG-1:0] upd_dots,
    output logic               upd_ready,
    input  logic [NUM_DIG-1:0] dig_en,
    input  logic               lz_blank,
    output logic [NUM_DIG-1:0] dig_n,
    output logic [SEG_W-1:0]   seg_n,
    output logic               dp_n,
    output logic               frame_tick
);

    localparam int unsigned SLOT_CYC = CLK_HZ / SCAN_HZ;
    localparam int unsigned CNT_W    = $clog2(SLOT_CYC);

    localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(SLOT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_PRE_LAST  = CNT_W'(SLOT_CYC - 2);
    localparam logic [CNT_W-1:0] CNT_BLANK_END = CNT_W'(BLANK_CYC - 1);

    logic [0:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_idx;
    disp_word_t         r_active;
    disp_word_t         r_pend;
    logic               r_pend_vld;
    logic               r_ready;
    logic [NUM_DIG-1:0] r_dig_n;
    logic [SEG_W-1:0]   r_seg_n;
    logic               r_dp_n;
    logic               r_tick;

    logic [0:0]         w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [1:0]         w_idx_nxt;
    disp_word_t         w_active_nxt;
    disp_word_t         w_pend_nxt;
    logic               w_pend_vld_nxt;
    logic               w_ready_nxt;
    logic [NUM_DIG-1:0] w_dig_nxt;
    logic [SEG_W-1:0]   w_seg_nxt;
    logic               w_dp_nxt;
    logic               w_tick_nxt;

    logic [3:0]         w_nib;
    logic               w_dot;
    logic [SEG_W-1:0]   w_seg_dec;
    logic [NUM_DIG-1:0] w_sel_n;
    logic               w_z3;
    logic               w_z2;
    logic               w_z1;
    logic               w_lz_hit;

    // Current digit's nibble, dot and active-low select
    assign w_nib   = 4'(r_active.word >> {r_idx, 2'b00});
    assign w_dot   = r_active.dots[r_idx];
    assign w_sel_n = 4'(~(4'b0001 << r_idx));

    // Leading zeros accumulate from the leftmost digit downwards
    assign w_z3 = (r_active.word[15:12] == 4'h0);
    assign w_z2 = w_z3 && (r_active.word[11:8] == 4'h0);
    assign w_z1 = w_z2 && (r_active.word[7:4] == 4'h0);

    always_comb begin
        w_lz_hit = 1'b0;
        case (r_idx)
            2'd1:    w_lz_hit = w_z1;
            2'd2:    w_lz_hit = w_z2;
            2'd3:    w_lz_hit = w_z3;
            default: w_lz_hit = 1'b0;
        endcase
        w_lz_hit = w_lz_hit && lz_blank;
    end

    seg_hex_decode u_dec (
        .i_nib     (w_nib),
        .o_seg_n_c (w_seg_dec)
    );

    // Next state: slot sequencing, handshake and display outputs
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt + CNT_W'(1);
        w_idx_nxt      = r_idx;
        w_active_nxt   = r_active;
        w_pend_nxt     = r_pend;
        w_pend_vld_nxt = r_pend_vld;
        w_dig_nxt      = DIG_OFF;
        w_seg_nxt      = SEG_BLANK;
        w_dp_nxt       = 1'b1;
        // Registered, so raised one cycle early to land on the wrap cycle
        w_tick_nxt     = (r_idx == 2'd3) && (r_cnt == CNT_PRE_LAST);

        if (r_cnt == CNT_LAST) begin
            w_cnt_nxt = '0;
            w_idx_nxt = r_idx + 2'd1;
        end

        case (r_state)
            ST_BLANK: begin
                if (r_cnt == CNT_BLANK_END) begin
                    w_state_nxt = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_BLANK;
                end
                // A zero-blanked digit keeps its select only to light its dot
                if (dig_en[r_idx]) begin
                    if (!w_lz_hit) begin
                        w_dig_nxt = w_sel_n;
                        w_seg_nxt = w_seg_dec;
                        w_dp_nxt  = ~w_dot;
                    end else if (w_dot) begin
                        w_dig_nxt = w_sel_n;
                        w_dp_nxt  = 1'b0;
                    end
                end
            end
            default: w_state_nxt = ST_BLANK;
        endcase

        // Commit only at a frame end; ready is low exactly while pending is held
        if (r_tick && r_pend_vld) begin
            w_active_nxt   = r_pend;
            w_pend_vld_nxt = 1'b0;
        end else if (upd_valid && r_ready) begin
            w_pend_nxt     = '{word: upd_data, dots: upd_dots};
            w_pend_vld_nxt = 1'b1;
        end
        w_ready_nxt = ~w_pend_vld_nxt;
    end

    always_ff @(posedge FPGA_CLK) begin
        if (!RESET_BUT) begin
            r_state    <= ST_BLANK;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_active   <= '0;
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
            r_ready    <= 1'b0;
            r_dig_n    <= DIG_OFF;
            r_seg_n    <= SEG_BLANK;
            r_dp_n     <= 1'b1;
            r_tick     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_idx      <= w_idx_nxt;
            r_active   <= w_active_nxt;
            r_pend     <= w_pend_nxt;
            r_pend_vld <= w_pend_vld_nxt;
            r_ready    <= w_ready_nxt;
            r_dig_n    <= w_dig_nxt;
            r_seg_n    <= w_seg_nxt;
            r_dp_n     <= w_dp_nxt;
            r_tick     <= w_tick_nxt;
        end
    end

    assign upd_ready  = r_ready;
    assign dig_n      = r_dig_n;
    assign seg_n      = r_seg_n;
    assign dp_n       = r_dp_n;
    assign frame_tick = r_tick;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with 20-cycle slots (4 blank) and 80-cycle frames.
// A cycle model pushes expected outputs each clock; a negedge monitor pops
// and compares. Directed spot checks use constants worked out by hand.
module tb_seg_scan_ctrl;

    logic        FPGA_CLK  = 1'b0;
    logic        RESET_BUT = 1'b0;
    logic        upd_valid = 1'b0;
    logic [15:0] upd_data  = 16'h0;
    logic [3:0]  upd_dots  = 4'h0;
    logic [3:0]  dig_en    = 4'hF;
    logic        lz_blank  = 1'b0;
    logic        upd_ready;
    logic [3:0]  dig_n;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic        frame_tick;

    seg_scan_ctrl #(
        .CLK_HZ    (1000),
        .SCAN_HZ   (50),
        .BLANK_CYC (4)
    ) dut (
        .FPGA_CLK   (FPGA_CLK),
        .RESET_BUT  (RESET_BUT),
        .upd_valid  (upd_valid),
        .upd_data   (upd_data),
        .upd_dots   (upd_dots),
        .upd_ready  (upd_ready),
        .dig_en     (dig_en),
        .lz_blank   (lz_blank),
        .dig_n      (dig_n),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .frame_tick (frame_tick)
    );

    always #5 FPGA_CLK = ~FPGA_CLK;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int mask_bad = 0;
    logic mask_win = 1'b0;

    logic [6:0]  seg_tab [16];
    logic [13:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    initial begin
        seg_tab = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};
    end

    // Cycle index since the last reset edge
    always @(posedge FPGA_CLK) cyc <= RESET_BUT ? cyc + 1 : 0;

    // Reference model: expected outputs for the cycle after this edge
    int          m_cnt = 0;
    int          m_idx = 0;
    logic [15:0] m_act = 16'h0;
    logic [3:0]  m_adots = 4'h0;
    logic [15:0] m_pend = 16'h0;
    logic [3:0]  m_pdots = 4'h0;
    logic        m_pv = 1'b0;
    logic        m_rdy = 1'b0;
    logic        m_tick = 1'b0;

    always @(posedge FPGA_CLK) begin
        logic [3:0] e_dig;
        logic [6:0] e_seg;
        logic       e_dp, e_tick, e_rdy, dot, lzb, z3, z2, z1;
        logic [3:0] nib;
        logic [3:0] one;
        one = 4'b0001;
        if (!RESET_BUT) begin
            m_cnt = 0; m_idx = 0; m_act = 16'h0; m_adots = 4'h0;
            m_pend = 16'h0; m_pdots = 4'h0; m_pv = 1'b0; m_rdy = 1'b0; m_tick = 1'b0;
            exp_q.push_back({4'hF, 7'h7F, 1'b1, 1'b0, 1'b0});
        end else begin
            e_dig = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
            nib = m_act[m_idx*4 +: 4];
            dot = m_adots[m_idx];
            z3  = (m_act[15:12] == 4'h0);
            z2  = z3 && (m_act[11:8] == 4'h0);
            z1  = z2 && (m_act[7:4] == 4'h0);
            lzb = lz_blank && ((m_idx == 3 && z3) || (m_idx == 2 && z2) || (m_idx == 1 && z1));
            if (m_cnt >= 4 && dig_en[m_idx]) begin
                if (!lzb) begin
                    e_dig = ~(one << m_idx); e_seg = seg_tab[nib]; e_dp = ~dot;
                end else if (dot) begin
                    e_dig = ~(one << m_idx); e_dp = 1'b0;
                end
            end
            e_tick = (m_cnt == 18) && (m_idx == 3);
            if (m_tick && m_pv) begin
                m_act = m_pend; m_adots = m_pdots; m_pv = 1'b0;
            end else if (upd_valid && m_rdy) begin
                m_pend = upd_data; m_pdots = upd_dots; m_pv = 1'b1;
            end
            e_rdy = !m_pv;
            if (m_cnt == 19) begin
                m_cnt = 0; m_idx = (m_idx + 1) % 4;
            end else begin
                m_cnt = m_cnt + 1;
            end
            m_tick = e_tick; m_rdy = e_rdy;
            exp_q.push_back({e_dig, e_seg, e_dp, e_tick, e_rdy});
        end
    end

    always @(negedge FPGA_CLK) begin
        logic [13:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb", 32'({dig_n, seg_n, dp_n, frame_tick, upd_ready}), 32'(e));
        end
        if (mask_win && (dig_n[1] == 1'b0 || dig_n[3] == 1'b0)) mask_bad++;
    end

    task automatic wait_cyc(input int n);
        int guard = 0;
        while (cyc < n && guard < 3000) begin
            @(negedge FPGA_CLK);
            guard++;
        end
        if (cyc != n) chk("wait_cyc", 32'(cyc), 32'(n));
    endtask

    task automatic send(input logic [15:0] d, input logic [3:0] dots);
        upd_valid = 1'b1; upd_data = d; upd_dots = dots;
        @(negedge FPGA_CLK);
        upd_valid = 1'b0;
    endtask

    task automatic chk_disp(input string tag, input logic [3:0] dg, input logic [6:0] sg, input logic dp);
        chk({tag, "_dig"}, 32'(dig_n), 32'(dg));
        chk({tag, "_seg"}, 32'(seg_n), 32'(sg));
        chk({tag, "_dp"},  32'(dp_n),  32'(dp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset, idle scan, frame tick period
        repeat (3) @(posedge FPGA_CLK);
        @(negedge FPGA_CLK);
        chk_disp("rst", 4'hF, 7'h7F, 1'b1);
        chk("rst_rdy", 32'(upd_ready), 32'h0);
        chk("rst_tick", 32'(frame_tick), 32'h0);
        RESET_BUT = 1'b1;
        wait_cyc(1);   chk("rdy_up", 32'(upd_ready), 32'h1);
        wait_cyc(4);   chk_disp("blank0", 4'hF, 7'h7F, 1'b1);
        wait_cyc(5);   chk_disp("show0", 4'hE, 7'h01, 1'b1);
        wait_cyc(20);  chk_disp("show0_end", 4'hE, 7'h01, 1'b1);
        wait_cyc(21);  chk_disp("blank1", 4'hF, 7'h7F, 1'b1);
        wait_cyc(25);  chk_disp("show1", 4'hD, 7'h01, 1'b1);
        wait_cyc(78);  chk("tick78", 32'(frame_tick), 32'h0);
        wait_cyc(79);  chk("tick79", 32'(frame_tick), 32'h1);
        wait_cyc(80);  chk("tick80", 32'(frame_tick), 32'h0);

        // 2: mid-frame load, commit at frame end
        wait_cyc(100); send(16'h12AF, 4'b0010);
        chk("busy", 32'(upd_ready), 32'h0);
        wait_cyc(159); chk("busy159", 32'(upd_ready), 32'h0);
        wait_cyc(160); chk("rdy160", 32'(upd_ready), 32'h1);
        wait_cyc(170); chk_disp("w_d1", 4'hE, 7'h38, 1'b1);
        wait_cyc(190); chk_disp("w_d2", 4'hD, 7'h08, 1'b0);
        wait_cyc(210); chk_disp("w_d3", 4'hB, 7'h12, 1'b1);
        wait_cyc(230); chk_disp("w_d4", 4'h7, 7'h4F, 1'b1);

        // 3: leading-zero blanking on, then off
        wait_cyc(245); lz_blank = 1'b1; send(16'h0005, 4'b0000);
        wait_cyc(330); chk_disp("lz_d1", 4'hE, 7'h24, 1'b1);
        wait_cyc(350); chk_disp("lz_d2", 4'hF, 7'h7F, 1'b1);
        wait_cyc(370); chk_disp("lz_d3", 4'hF, 7'h7F, 1'b1);
        wait_cyc(390); chk_disp("lz_d4", 4'hF, 7'h7F, 1'b1);
        wait_cyc(395); lz_blank = 1'b0;
        wait_cyc(410); chk_disp("nolz_d1", 4'hE, 7'h24, 1'b1);
        wait_cyc(430); chk_disp("nolz_d2", 4'hD, 7'h01, 1'b1);
        wait_cyc(450); chk_disp("nolz_d3", 4'hB, 7'h01, 1'b1);
        wait_cyc(470); chk_disp("nolz_d4", 4'h7, 7'h01, 1'b1);

        // 4: digit enable mask, frame length unchanged
        wait_cyc(475); dig_en = 4'b0101;
        wait_cyc(480); mask_win = 1'b1;
        wait_cyc(490); chk_disp("en_d1", 4'hE, 7'h24, 1'b1);
        wait_cyc(510); chk_disp("en_d2", 4'hF, 7'h7F, 1'b1);
        wait_cyc(530); chk_disp("en_d3", 4'hB, 7'h01, 1'b1);
        wait_cyc(550); chk_disp("en_d4", 4'hF, 7'h7F, 1'b1);
        wait_cyc(558); chk("en_tick558", 32'(frame_tick), 32'h0);
        wait_cyc(559); chk("en_tick559", 32'(frame_tick), 32'h1);
        wait_cyc(560); mask_win = 1'b0; dig_en = 4'hF;
        chk("en_mask", 32'(mask_bad), 32'h0);

        // 5: transfer on the frame_tick cycle, busy valid ignored
        wait_cyc(639); chk("ft_tick", 32'(frame_tick), 32'h1);
        send(16'h3C7B, 4'b1000);
        chk("ft_busy", 32'(upd_ready), 32'h0);
        wait_cyc(650); chk_disp("ft_old", 4'hE, 7'h24, 1'b1);
        wait_cyc(700); send(16'hFFFF, 4'hF);
        wait_cyc(719); chk("ft_busy719", 32'(upd_ready), 32'h0);
        wait_cyc(720); chk("ft_rdy720", 32'(upd_ready), 32'h1);
        wait_cyc(730); chk_disp("ft_d1", 4'hE, 7'h60, 1'b1);
        wait_cyc(750); chk_disp("ft_d2", 4'hD, 7'h0F, 1'b1);
        wait_cyc(770); chk_disp("ft_d3", 4'hB, 7'h31, 1'b1);
        wait_cyc(790); chk_disp("ft_d4", 4'h7, 7'h06, 1'b0);

        // 6: reset mid-show with a pending word
        wait_cyc(805); send(16'h8888, 4'hF);
        wait_cyc(830); RESET_BUT = 1'b0;
        @(negedge FPGA_CLK);
        chk_disp("mrst", 4'hF, 7'h7F, 1'b1);
        chk("mrst_rdy", 32'(upd_ready), 32'h0);
        chk("mrst_tick", 32'(frame_tick), 32'h0);
        RESET_BUT = 1'b1;
        wait_cyc(1);   chk("mrst_rdy1", 32'(upd_ready), 32'h1);
        wait_cyc(5);   chk_disp("mrst_d1", 4'hE, 7'h01, 1'b1);
        wait_cyc(79);  chk("mrst_tick79", 32'(frame_tick), 32'h1);
        wait_cyc(85);  chk_disp("mrst_nopend", 4'hE, 7'h01, 1'b1);

        repeat (2) @(negedge FPGA_CLK);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
